fetch_decode_buf: RTL and testbench
===================================

# fetch_decode_buf

Parametrised fetch-to-decode buffer with elastic handshake, replacing the single-entry fetch/decode pipeline register. Holds up to DEPTH fetched instructions with their addresses in a circular FIFO. Presents the oldest entry to decode with valid/ready flow control. Supports a decode-side stall (`hold_en`) and a branch/jump flush, and emits a NOP whenever no instruction is available.

## Interface
- `XLEN`, 32: instruction and address width.
- `DEPTH`, 2: entry count; power of two, 2..8.
- `NOP_INS`, 32'h0000_0013: instruction driven when the buffer is empty (`addi x0,x0,0`).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ins_i`  in  XLEN  fetched instruction.
- `ins_addr_i`  in  XLEN  fetched instruction address.
- `in_valid_i`  in  1  fetch offers `ins_i`/`ins_addr_i`.
- `in_ready_o`  out  1  buffer can accept this cycle.
- `flush_i`  in  1  discard all buffered entries (taken branch/jump).
- `hold_en`  in  1  pipeline stall from the hazard unit.
- `ins_o`  out  XLEN  head instruction, or `NOP_INS`.
- `ins_addr_o`  out  XLEN  head address, or 0.
- `out_valid_o`  out  1  head entry is presented.
- `out_ready_i`  in  1  decode consumes the head.
- `count_o`  out  $clog2(DEPTH+1)  current occupancy.
- `misalign_o`  out  1  head address misaligned (present only with the macro).

## Operation
- Storage: DEPTH × {ins, addr[, misalign]}. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. `count` is a separate register.
- `in_ready_o` = (count != DEPTH) & !flush_i. It does not depend on `out_ready_i`, so there is no combinational path from decode to fetch.
- push = in_valid_i & in_ready_o.
- pop = out_valid_o & out_ready_i.
- `out_valid_o` = (count != 0) & !hold_en & !flush_i.
- Effect of `hold_en`: blocks pop only. Pushes continue until the buffer is full.
- Outputs when `out_valid_o` = 0 (empty, hold or flush): `ins_o` = `NOP_INS`, `ins_addr_o` = 0. Decode always sees a NOP bubble, never stale data.
- Priority per cycle: rst > flush_i > push/pop.
  - Flush: count←0, rd_ptr←wr_ptr. Any same-cycle push is dropped, because `in_ready_o` = 0 during flush.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- Full buffer: `in_ready_o` = 0 even if a pop occurs in the same cycle. A push into a slot freed that cycle is not permitted.
- Empty buffer: no bypass. An entry pushed in cycle N is first presented in cycle N+1.
- No overflow or underflow is possible. Pointers change only on a qualified push or pop.

## Timing
- Reset values (cycle after `rst`=1 sampled):
  - count_o = 0, out_valid_o = 0, in_ready_o = 1 (if flush_i = 0).
  - ins_o = NOP_INS, ins_addr_o = 0, misalign_o = 0.
  - Pointers = 0.
- Reset mid-operation discards all entries in that same edge.
- Latency: push in cycle N → visible on outputs in cycle N+1 when the buffer was empty.
- Throughput: 1 instruction/cycle sustained when in_valid_i = out_ready_i = 1.
- Outputs are functions of registers plus the `hold_en`/`flush_i` masks only.
- Flush in cycle N → count_o = 0 in N+1. The first post-flush push is accepted in N+1 and presented in N+2.

## Configuration
- Macro: `FETCH_BUF_MISALIGN_CHK_EN`.
- With the macro defined:
  - On push, `ins_addr_i[1:0] != 0` sets the entry's misalign bit and stores `NOP_INS` in place of `ins_i`.
  - `misalign_o` = head misalign bit & out_valid_o, for the trap unit.
- Without the macro: the `misalign_o` port and the misalign storage are absent, and instructions are stored unmodified.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then rst=0 → count_o=0, out_valid_o=0, ins_o=32'h0000_0013, ins_addr_o=0, in_ready_o=1.
- Streaming: push ins 0xA0..0xA7 at addr 0x0..0x1C with out_ready_i=1 every cycle → outputs appear one cycle after each push, in order, and count_o stays ≤1.
- Fill and stall (DEPTH=4): push 5 words with out_ready_i=0 → in_ready_o=0 after 4 pushes, count_o=4, 5th word held by fetch. Then out_ready_i=1 → 4 pops in order, then the 5th word is accepted.
- Hold: count_o=2, hold_en=1 for 3 cycles → out_valid_o=0 and ins_o=NOP throughout; on release the head is the same entry as before the hold.
- Flush with simultaneous push: count_o=3, flush_i=1 and in_valid_i=1 (ins 0xBEEF) → next cycle count_o=0 and 0xBEEF is not stored. A push in the following cycle appears at the output one cycle later.
- Macro on: push addr 0x1002, ins 0x00A00093 → presented ins_o=0x00000013, misalign_o=1, ins_addr_o=0x1002. Pushing addr 0x1004 next → misalign_o=0.

Source files
------------

// File: rtl/fetch_decode_buf.sv
// Elastic fetch-to-decode buffer: DEPTH-entry circular FIFO of {instruction, address}
// with hold/flush masking and NOP bubbles. Optional misalignment tagging via FETCH_BUF_MISALIGN_CHK_EN.
module fetch_decode_buf #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 2,
    parameter logic [XLEN-1:0] NOP_INS = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [XLEN-1:0]            ins_i,
    input  logic [XLEN-1:0]            ins_addr_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    input  logic                       hold_en,
    output logic [XLEN-1:0]            ins_o,
    output logic [XLEN-1:0]            ins_addr_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
`ifdef FETCH_BUF_MISALIGN_CHK_EN
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       misalign_o
`else
    output logic [$clog2(DEPTH+1)-1:0] count_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [XLEN-1:0] ins_mem_r  [DEPTH];
    logic [XLEN-1:0] addr_mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            push_s;
    logic            pop_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic [XLEN-1:0] ins_wr_s;

`ifdef FETCH_BUF_MISALIGN_CHK_EN
    logic            mis_mem_r [DEPTH];
    logic            mis_wr_s;
`endif

    // Handshake qualification; ready never looks at out_ready_i so decode cannot reach fetch combinationally
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (flush_i) begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
        end else begin
            in_ready_s  = (count_r != FULL_C);
            out_valid_s = (count_r != {CW{1'b0}}) & ~hold_en;
        end
        push_s = in_valid_i & in_ready_s;
        pop_s  = out_valid_s & out_ready_i;
    end

    // Write data selection; misaligned fetches are replaced by a NOP and tagged
    always_comb begin
        ins_wr_s = ins_i;
`ifdef FETCH_BUF_MISALIGN_CHK_EN
        mis_wr_s = (ins_addr_i[1:0] != 2'b00);
        if (mis_wr_s) begin
            ins_wr_s = NOP_INS;
        end else begin
            ins_wr_s = ins_i;
        end
`endif
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            ins_mem_r[wr_ptr_r]  <= ins_wr_s;
            addr_mem_r[wr_ptr_r] <= ins_addr_i;
`ifdef FETCH_BUF_MISALIGN_CHK_EN
            mis_mem_r[wr_ptr_r]  <= mis_wr_s;
`endif
        end
    end

    // Pointers and occupancy; flush realigns the read pointer onto the write pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_i) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Output presentation: a NOP bubble whenever the head is not offered
    always_comb begin
        in_ready_o  = in_ready_s;
        out_valid_o = out_valid_s;
        count_o     = count_r;
        if (out_valid_s) begin
            ins_o      = ins_mem_r[rd_ptr_r];
            ins_addr_o = addr_mem_r[rd_ptr_r];
        end else begin
            ins_o      = NOP_INS;
            ins_addr_o = {XLEN{1'b0}};
        end
`ifdef FETCH_BUF_MISALIGN_CHK_EN
        misalign_o = mis_mem_r[rd_ptr_r] & out_valid_s;
`endif
    end

endmodule

// File: tb/tb_fetch_decode_buf.sv
// Self-checking bench for fetch_decode_buf (DEPTH=4): directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_fetch_decode_buf;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] ins_i;
    logic [XLEN-1:0] ins_addr_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic            flush_i;
    logic            hold_en;
    logic [XLEN-1:0] ins_o;
    logic [XLEN-1:0] ins_addr_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [CW-1:0]   count_o;
    logic            misalign_o;

    always #5 clk = ~clk;

`ifndef FETCH_BUF_MISALIGN_CHK_EN
    assign misalign_o = 1'b0;
`endif

    fetch_decode_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP_INS(NOP)) dut (
        .clk         (clk),
        .rst         (rst),
        .ins_i       (ins_i),
        .ins_addr_i  (ins_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .hold_en     (hold_en),
        .ins_o       (ins_o),
        .ins_addr_o  (ins_addr_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
`ifdef FETCH_BUF_MISALIGN_CHK_EN
        .count_o     (count_o),
        .misalign_o  (misalign_o)
`else
        .count_o     (count_o)
`endif
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
        logic        mis;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   last_push;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit   ev, er;
        ent_t h, e;
        @(negedge clk);
        er = (q.size() != DEPTH) && !flush_i;
        ev = (q.size() != 0) && !hold_en && !flush_i;
        h.ins = NOP; h.addr = 32'd0; h.mis = 1'b0;
        if (ev) h = q[0];
        check_eq("in_ready",  {63'd0, in_ready_o},  {63'd0, er});
        check_eq("out_valid", {63'd0, out_valid_o}, {63'd0, ev});
        check_eq("ins",       {32'd0, ins_o},       {32'd0, h.ins});
        check_eq("ins_addr",  {32'd0, ins_addr_o},  {32'd0, h.addr});
        check_eq("count",     64'(count_o),         64'(q.size()));
`ifdef FETCH_BUF_MISALIGN_CHK_EN
        check_eq("misalign",  {63'd0, misalign_o},  {63'd0, h.mis});
`endif
        @(posedge clk);
        last_push = 1'b0;
        if (rst || flush_i) begin
            q.delete();
        end else begin
            if (ev && out_ready_i) void'(q.pop_front());
            if (in_valid_i && er) begin
                e.addr = ins_addr_i;
`ifdef FETCH_BUF_MISALIGN_CHK_EN
                e.mis = (ins_addr_i[1:0] != 2'b00);
`else
                e.mis = 1'b0;
`endif
                e.ins = e.mis ? NOP : ins_i;
                q.push_back(e);
                last_push = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush_i = 1'b0; hold_en = 1'b0;
        in_valid_i = 1'b0; out_ready_i = 1'b0;
        ins_i = 32'd0; ins_addr_i = 32'd0;
    endtask

    initial begin
        int k;
        idle_inputs();
        // reset then idle
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        cycle();
        check_eq("rst_count", 64'(count_o), 64'd0);
        check_eq("rst_ins",   {32'd0, ins_o}, {32'd0, NOP});
        check_eq("rst_ready", {63'd0, in_ready_o}, 64'd1);

        // streaming at one word per cycle
        out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid_i = 1'b1; ins_i = 32'hA0 + i; ins_addr_i = 32'(i * 4);
            cycle();
            check_eq("stream_cnt", {63'd0, count_o <= CW'(1)}, 64'd1);
        end
        in_valid_i = 1'b0;
        cycle(); cycle();

        // fill to full with decode stalled, fifth word held by fetch
        out_ready_i = 1'b0; k = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid_i = 1'b1; ins_i = 32'hC0 + k; ins_addr_i = 32'h100 + 32'(k * 4);
            cycle();
            if (last_push) k++;
        end
        check_eq("fill_accepted", 64'(k), 64'd4);
        check_eq("fill_count", 64'(count_o), 64'd4);
        out_ready_i = 1'b1;
        for (int i = 0; i < 20 && k < 5; i++) begin
            ins_i = 32'hC0 + k; ins_addr_i = 32'h100 + 32'(k * 4);
            cycle();
            if (last_push) k++;
        end
        check_eq("fill_fifth", 64'(k), 64'd5);
        in_valid_i = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // hold with two entries buffered
        out_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_i = 1'b1; ins_i = 32'hD0 + i; ins_addr_i = 32'h200 + 32'(i * 4);
            cycle();
        end
        in_valid_i = 1'b0; hold_en = 1'b1; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        hold_en = 1'b0;
        @(negedge clk);
        check_eq("hold_head", {32'd0, ins_o}, 64'h0000_00D0);
        out_ready_i = 1'b0;
        cycle();
        flush_i = 1'b1; cycle(); flush_i = 1'b0;

        // flush colliding with a push
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; ins_i = 32'hE0 + i; ins_addr_i = 32'h300 + 32'(i * 4);
            cycle();
        end
        check_eq("pre_flush_cnt", 64'(count_o), 64'd3);
        flush_i = 1'b1; ins_i = 32'h0000_BEEF; ins_addr_i = 32'h400;
        cycle();
        flush_i = 1'b0;
        check_eq("flush_cnt", 64'(count_o), 64'd0);
        ins_i = 32'hF0; ins_addr_i = 32'h500;
        cycle();
        in_valid_i = 1'b0;
        @(negedge clk);
        check_eq("post_flush_ins", {32'd0, ins_o}, 64'h0000_00F0);
        cycle();
        out_ready_i = 1'b1; cycle(); cycle();

`ifdef FETCH_BUF_MISALIGN_CHK_EN
        // misaligned address tagging
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; ins_i = 32'h00A0_0093; ins_addr_i = 32'h1002;
        cycle();
        ins_addr_i = 32'h1004;
        cycle();
        in_valid_i = 1'b0;
        @(negedge clk);
        check_eq("mis_flag", {63'd0, misalign_o}, 64'd1);
        check_eq("mis_ins",  {32'd0, ins_o}, {32'd0, NOP});
        out_ready_i = 1'b1;
        cycle();
        @(negedge clk);
        check_eq("mis_clear", {63'd0, misalign_o}, 64'd0);
        check_eq("mis_next",  {32'd0, ins_o}, 64'h00A0_0093);
        cycle(); cycle();
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            flush_i     = ($urandom_range(0, 15) == 0);
            hold_en     = ($urandom_range(0, 3) == 0);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            ins_i       = $urandom;
            ins_addr_i  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
